song_sequencer: RTL and testbench

//   Playback controller for the note ROM and the tone generator. Walks the note-ROM address space at a fixed step tempo and latches each 8-bit note code.

---
 rtl/song_pkg.sv | 33 +++
 rtl/step_timer.sv | 38 +++
 rtl/song_sequencer.sv | 141 ++++++++++++++
 tb/tb_song_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: FSM state codes, special note
// codes and helpers that split a note code into its pitch fields.
package song_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ADDR   = 3'd1;
    localparam state_t ST_LOAD   = 3'd2;
    localparam state_t ST_PLAY   = 3'd3;
    localparam state_t ST_PAUSED = 3'd4;

    localparam logic [7:0] NOTE_REST = 8'h00;
    localparam logic [7:0] NOTE_END  = 8'hFF;

    // Bits [5:0] of a note code hold octave*12 + semitone.
    function automatic logic [5:0] note_pitch(input logic [7:0] code);
        return code[5:0];
    endfunction

    function automatic logic [2:0] note_octave(input logic [7:0] code);
        logic [5:0] pitch;
        pitch = code[5:0];
        return 3'(pitch / 6'd12);
    endfunction

    function automatic logic [3:0] note_semitone(input logic [7:0] code);
        logic [5:0] pitch;
        pitch = code[5:0];
        return 4'(pitch % 6'd12);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter with a hold enable and zero flag; it saturates at zero.
// count_next exposes the value the counter takes at the next edge.
module step_timer #(
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count_next,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_next = cnt_d;
    assign zero       = (cnt_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// Playback controller: steps through the note ROM at a fixed tempo, latches
// each note code and gates the tone generator with an articulation gap.
module song_sequencer
    import song_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int MAX_ADDR    = 255,
    parameter int STEP_CYCLES = 4194304,
    parameter int GAP_CYCLES  = 262144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              song_sel,
    output logic              rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        note_code,
    output logic              note_on,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    // ADDR and LOAD consume two cycles of every step, so the counter covers the rest.
    localparam logic [CNT_W-1:0]  STEP_LOAD = CNT_W'(STEP_CYCLES - 3);
    localparam logic [CNT_W-1:0]  GAP_LEN   = CNT_W'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_sel_q, rom_sel_d;
    logic [7:0]        note_code_q, note_code_d;
    logic              note_on_q, note_on_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_zero;
    logic [CNT_W-1:0]  cnt_d;

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_val   (STEP_LOAD),
        .en         (tmr_en),
        .count_next (cnt_d),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        rom_sel_d   = rom_sel_q;
        note_code_d = note_code_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;

        if (stop) begin
            state_d     = ST_IDLE;
            note_code_d = NOTE_REST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play && !pause) begin
                        rom_addr_d = '0;
                        rom_sel_d  = song_sel;
                        state_d    = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (rom_data == NOTE_END) begin
                        note_code_d = NOTE_REST;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        note_code_d = rom_data;
                        tmr_load    = 1'b1;
                        state_d     = pause ? ST_PAUSED : ST_PLAY;
                    end
                end
                // Releasing pause counts as a normal PLAY cycle so a pause of N cycles delays the step by exactly N.
                ST_PLAY, ST_PAUSED: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (!tmr_zero) begin
                        tmr_en  = 1'b1;
                        state_d = ST_PLAY;
                    end else if (rom_addr_q == LAST_ADDR) begin
                        note_code_d = NOTE_REST;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = ST_ADDR;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        note_on_d = (state_d == ST_PLAY) && (note_code_d != NOTE_REST) && (cnt_d >= GAP_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            rom_sel_q   <= 1'b0;
            note_code_q <= NOTE_REST;
            note_on_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rom_sel_q   <= rom_sel_d;
            note_code_q <= note_code_d;
            note_on_q   <= note_on_d;
            done_q      <= done_d;
        end
    end

    assign rom_sel   = rom_sel_q;
    assign rom_addr  = rom_addr_q;
    assign note_code = note_code_q;
    assign note_on   = note_on_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a per-cycle expected trace is queued as
// each song is started and popped against the DUT outputs every cycle.
module tb_song_sequencer;

   localparam int ADDR_W      = 8;
   localparam int MAX_ADDR    = 3;
   localparam int STEP_CYCLES = 8;
   localparam int GAP_CYCLES  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       play = 1'b0;
   logic       pause = 1'b0;
   logic       stop = 1'b0;
   logic       song_sel = 1'b0;
   logic       rom_sel;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] note_code;
   logic       note_on;
   logic       busy;
   logic       done;

   logic [7:0] rom [4];

   typedef struct packed {
      logic       sel;
      logic [7:0] addr;
      logic [7:0] code;
      logic       on;
      logic       busy;
      logic       done;
   } obsT;

   obsT expQ[$];
   int  nAsserts = 0;
   int  nFails = 0;

   song_sequencer #(
      .ADDR_W      (ADDR_W),
      .MAX_ADDR    (MAX_ADDR),
      .STEP_CYCLES (STEP_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .play      (play),
      .pause     (pause),
      .stop      (stop),
      .song_sel  (song_sel),
      .rom_sel   (rom_sel),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .note_code (note_code),
      .note_on   (note_on),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Note ROM model: synchronous read, data valid one cycle after the address.
   always @(posedge clk) begin
      rom_data <= rom[rom_addr[1:0]];
   end

   // Watchdog so the run always ends even if something goes badly wrong.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic obsT mk(input logic sel, input logic [7:0] addr, input logic [7:0] code,
                              input logic on, input logic bsy, input logic dn);
      obsT o;
      o = {sel, addr, code, on, bsy, dn};
      return o;
   endfunction

   function automatic string fmtObs(input obsT o);
      return $sformatf("sel=%0d addr=%0d code=%0d on=%0d busy=%0d done=%0d",
                       o.sel, o.addr, o.code, o.on, o.busy, o.done);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic pl, input logic pa, input logic st, input logic sel);
      play     = pl;
      pause    = pa;
      stop     = st;
      song_sel = sel;
   endtask

   task automatic checkOutput(input string tag);
      obsT obs;
      obsT exp;
      obs = {rom_sel, rom_addr, note_code, note_on, busy, done};
      nAsserts++;
      if (expQ.size() == 0) begin
         nFails++;
         $error("[TB] FAIL %s: observed %s, required a queued expectation (scoreboard empty)", tag, fmtObs(obs));
      end else begin
         exp = expQ.pop_front();
         assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %s, required %s", tag, fmtObs(obs), fmtObs(exp));
         end
      end
   endtask

   // Expected per-cycle trace of a song started by a play pulse: entry k is
   // the output state k cycles after the accepting edge. Each step is 8 cycles:
   // address, load, then 6 note cycles of which the first 4 are gated on.
   task automatic genSong(input logic sel);
      logic [7:0] prev;
      logic [7:0] cur;
      prev = 8'd0;
      for (int s = 0; s < 4; s++) begin
         cur = rom[s[1:0]];
         expQ.push_back(mk(sel, 8'(s), prev, 1'b0, 1'b1, 1'b0));
         expQ.push_back(mk(sel, 8'(s), prev, 1'b0, 1'b1, 1'b0));
         if (cur == 8'hFF) begin
            expQ.push_back(mk(sel, 8'(s), 8'd0, 1'b0, 1'b0, 1'b1));
            expQ.push_back(mk(sel, 8'(s), 8'd0, 1'b0, 1'b0, 1'b0));
            return;
         end
         for (int k = 0; k < 6; k++) begin
            expQ.push_back(mk(sel, 8'(s), cur, (k < 4) && (cur != 8'd0), 1'b1, 1'b0));
         end
         prev = cur;
      end
      expQ.push_back(mk(sel, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1));
      expQ.push_back(mk(sel, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic startSong(input logic sel);
      applyStimulus(1'b1, 1'b0, 1'b0, sel);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, sel);
   endtask

   task automatic runTrace(input string name);
      int t;
      t = 1;
      while (expQ.size() > 0) begin
         checkOutput($sformatf("%s t%0d", name, t));
         tick();
         t++;
      end
   endtask

   // Directed sequence of scenarios, each followed against its queued trace.
   initial begin
      int n;

      rom[0] = 8'd0; rom[1] = 8'd0; rom[2] = 8'd0; rom[3] = 8'd0;
      @(negedge clk);
      tick();
      expQ.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      checkOutput("reset");
      rst_n = 1'b1;
      tick();

      // Basic song ending on the end marker, with repeated notes.
      rom[0] = 8'd22; rom[1] = 8'd22; rom[2] = 8'd25; rom[3] = 8'hFF;
      genSong(1'b0);
      startSong(1'b0);
      runTrace("basic");

      // Leading rest, then natural end at the last address.
      rom[0] = 8'd0; rom[1] = 8'd18; rom[2] = 8'd18; rom[3] = 8'd18;
      genSong(1'b0);
      startSong(1'b0);
      runTrace("maxaddr");
      expQ.push_back(mk(1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0));
      expQ.push_back(mk(1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0));
      runTrace("maxaddr_hold");

      // Pause for 5 cycles in step 0: 5 silent held cycles inserted.
      rom[0] = 8'd22; rom[1] = 8'd25; rom[2] = 8'd27; rom[3] = 8'hFF;
      genSong(1'b0);
      for (int i = 0; i < 5; i++) begin
         expQ.insert(4, mk(1'b0, 8'd0, 8'd22, 1'b0, 1'b1, 1'b0));
      end
      n = expQ.size();
      startSong(1'b0);
      for (int t = 1; t <= n; t++) begin
         checkOutput($sformatf("pause t%0d", t));
         if (t == 4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         if (t == 9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end

      // Stop with simultaneous play mid-step, then a restart one cycle later.
      genSong(1'b0);
      startSong(1'b0);
      for (int t = 1; t <= 12; t++) begin
         checkOutput($sformatf("stop t%0d", t));
         tick();
      end
      expQ.delete();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      expQ.push_back(mk(1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0));
      checkOutput("stop_idle");
      genSong(1'b0);
      startSong(1'b0);
      runTrace("restart");

      // Song select latched at play; later select toggles and a busy play are ignored.
      genSong(1'b1);
      n = expQ.size();
      startSong(1'b1);
      for (int t = 1; t <= n; t++) begin
         checkOutput($sformatf("songsel t%0d", t));
         if (t == 6)  applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         if (t == 20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         if (t == 21) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end

      // Asynchronous reset in the middle of a step.
      genSong(1'b1);
      startSong(1'b1);
      for (int t = 1; t <= 5; t++) begin
         checkOutput($sformatf("rst t%0d", t));
         tick();
      end
      expQ.delete();
      #2;
      rst_n = 1'b0;
      #1;
      expQ.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      checkOutput("rst_async");
      tick();
      expQ.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      checkOutput("rst_held");
      rst_n = 1'b1;
      tick();
      tick();
      expQ.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      checkOutput("rst_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
